// File: rtl/grf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : grf_wb_arbiter
// Brief    : Shares the GRF write port between pipeline writeback (priority)
//            and a 1-entry MDU result buffer; raises stall_req on RAW/starvation.
//            Optional buffered-wait counter enabled by macro GRF_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module grf_wb_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic [31:0] wb_pc,
    input  logic        md_valid,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    input  logic [31:0] md_pc,
    output logic        md_ready,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc,
    output logic        stall_req,
    output logic [15:0] perf_wait_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_wait_max = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] c_force_at = CNT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_buf_valid;
    logic [4:0]         r_buf_addr;
    logic [31:0]        r_buf_data;
    logic [31:0]        r_buf_pc;
    logic [CNT_W-1:0]   r_wait_cnt;

    logic w_wb_active;
    logic w_accept;
    logic w_drain;
    logic w_drop;
    logic w_discard;
    logic w_clear;
    logic w_blocked;
    logic w_raw;

    // Gating with reset keeps grf_we low while reset is held, even if wb_we is up.
    assign w_wb_active = reset & wb_we & (wb_addr != 5'd0);
    assign md_ready    = ~r_buf_valid;
    assign w_accept    = md_valid & ~r_buf_valid;
    assign w_drop      = r_buf_valid & (r_buf_addr == 5'd0);
    assign w_drain     = r_buf_valid & (r_buf_addr != 5'd0) & ~w_wb_active;
    assign w_discard   = r_buf_valid & w_wb_active & (wb_addr == r_buf_addr);
    assign w_clear     = w_drop | w_drain | w_discard;
    assign w_blocked   = r_buf_valid & (r_buf_addr != 5'd0) & w_wb_active & ~w_discard;
    assign w_raw       = r_buf_valid & (r_buf_addr != 5'd0) &
                         ((rs_addr == r_buf_addr) | (rt_addr == r_buf_addr));
    assign stall_req   = (r_state == FORCE) | w_raw;

    always_comb begin
        grf_we = 1'b0;
        grf_a3 = 5'd0;
        grf_wd = 32'd0;
        grf_pc = 32'd0;
        if (w_wb_active) begin
            grf_we = 1'b1;
            grf_a3 = wb_addr;
            grf_wd = wb_data;
            grf_pc = wb_pc;
        end else if (w_drain) begin
            grf_we = 1'b1;
            grf_a3 = r_buf_addr;
            grf_wd = r_buf_data;
            grf_pc = r_buf_pc;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next_state = PEND;
            end
            PEND: begin
                if (w_clear)
                    w_next_state = IDLE;
                else if (w_blocked && (r_wait_cnt == c_force_at))
                    w_next_state = FORCE;
            end
            FORCE: begin
                if (w_clear) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_buf_valid <= 1'b0;
            r_buf_addr  <= 5'd0;
            r_buf_data  <= 32'd0;
            r_buf_pc    <= 32'd0;
            r_wait_cnt  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_buf_valid <= 1'b1;
                r_buf_addr  <= md_addr;
                r_buf_data  <= md_data;
                r_buf_pc    <= md_pc;
            end else if (w_clear) begin
                r_buf_valid <= 1'b0;
            end
            if (w_clear)
                r_wait_cnt <= '0;
            else if (w_blocked && (r_wait_cnt != c_wait_max))
                r_wait_cnt <= r_wait_cnt + c_cnt_one;
        end
    end

`ifdef GRF_ARB_PERF_EN
    logic [15:0] r_perf_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_perf_cnt <= 16'd0;
        else if (r_buf_valid && !w_drain && (r_perf_cnt != 16'hFFFF))
            r_perf_cnt <= r_perf_cnt + 16'd1;
    end

    assign perf_wait_cnt = r_perf_cnt;
`else
    assign perf_wait_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_grf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_grf_wb_arbiter
// Brief    : Directed scenarios plus randomized run against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grf_wb_arbiter;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we, md_valid, md_ready, grf_we, stall_req;
    logic [4:0]  wb_addr, md_addr, rs_addr, rt_addr, grf_a3;
    logic [31:0] wb_data, wb_pc, md_data, md_pc, grf_wd, grf_pc;
    logic [15:0] perf_wait_cnt;

    int errors = 0;
    int checks = 0;

    grf_wb_arbiter #(.MAX_WAIT(MAXW), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
        .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_pc(md_pc),
        .md_ready(md_ready), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .stall_req(stall_req), .perf_wait_cnt(perf_wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_we = 0; wb_addr = 0; wb_data = 0; wb_pc = 0;
        md_valid = 0; md_addr = 0; md_data = 0; md_pc = 0;
        rs_addr = 0; rt_addr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        tick(); tick();
        reset = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0;
        md_valid = 1; md_addr = 5'd3; wb_we = 1; wb_addr = 5'd4; wb_data = 32'hABCD;
        @(negedge clk);
        checks++;
        if ({grf_we, stall_req, md_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reset_outs: we/stall/ready=%b want 001", {grf_we, stall_req, md_ready});
        end
        checks++;
        if ({grf_a3, grf_wd, grf_pc, perf_wait_cnt} !== 85'd0) begin
            errors++;
            $display("FAIL reset_zero: a3=%0d wd=%h pc=%h perf=%0d want all 0", grf_a3, grf_wd, grf_pc, perf_wait_cnt);
        end
        tick();
        idle_inputs();
        reset = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (grf_we !== 1'b0 || md_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_release_%0d: we=%b ready=%b want 0 1", i, grf_we, md_ready);
            end
            tick();
        end
    endtask

    task automatic test_idle_mdu();
        do_reset();
        md_valid = 1; md_addr = 5'd5; md_data = 32'h0000_1234; md_pc = 32'h3008;
        @(negedge clk);
        checks++;
        if (md_ready !== 1'b1 || grf_we !== 1'b0) begin
            errors++;
            $display("FAIL idle_accept: ready=%b we=%b want 1 0", md_ready, grf_we);
        end
        tick();
        md_valid = 0;
        @(negedge clk);
        checks++;
        if ({grf_we, grf_a3, grf_wd, grf_pc} !== {1'b1, 5'd5, 32'h1234, 32'h3008}) begin
            errors++;
            $display("FAIL idle_write: we=%b a3=%0d wd=%h pc=%h want 1 5 1234 3008", grf_we, grf_a3, grf_wd, grf_pc);
        end
        tick();
        @(negedge clk);
        checks++;
        if (md_ready !== 1'b1 || grf_we !== 1'b0) begin
            errors++;
            $display("FAIL idle_after: ready=%b we=%b want 1 0", md_ready, grf_we);
        end
        tick();
    endtask

    task automatic test_drop_zero();
        do_reset();
        md_valid = 1; md_addr = 5'd0; md_data = 32'hDEAD; md_pc = 32'h40;
        tick();
        md_valid = 0;
        @(negedge clk);
        checks++;
        if ({grf_we, md_ready, stall_req} !== 3'b000) begin
            errors++;
            $display("FAIL drop_zero: we/ready/stall=%b want 000", {grf_we, md_ready, stall_req});
        end
        tick();
        @(negedge clk);
        checks++;
        if (md_ready !== 1'b1 || grf_we !== 1'b0) begin
            errors++;
            $display("FAIL drop_zero_after: ready=%b we=%b want 1 0", md_ready, grf_we);
        end
        tick();
    endtask

    task automatic test_conflict();
        do_reset();
        md_valid = 1; md_addr = 5'd8; md_data = 32'hAAAA_0008; md_pc = 32'h100;
        wb_we = 1; wb_addr = 5'd9;
        for (int i = 0; i < 3; i++) begin
            wb_data = 32'h9000 + i; wb_pc = 32'h200 + 4 * i;
            @(negedge clk);
            checks++;
            if ({grf_we, grf_a3, grf_wd, md_ready} !== {1'b1, 5'd9, 32'h9000 + i, (i == 0)}) begin
                errors++;
                $display("FAIL conflict_pipe_%0d: we=%b a3=%0d wd=%h ready=%b", i, grf_we, grf_a3, grf_wd, md_ready);
            end
            tick();
            md_valid = 0;
        end
        wb_we = 0;
        @(negedge clk);
        checks++;
        if ({grf_we, grf_a3, grf_wd, grf_pc} !== {1'b1, 5'd8, 32'hAAAA_0008, 32'h100}) begin
            errors++;
            $display("FAIL conflict_mdu: we=%b a3=%0d wd=%h pc=%h want 1 8 aaaa0008 100", grf_we, grf_a3, grf_wd, grf_pc);
        end
        tick();
    endtask

    task automatic test_starvation();
        do_reset();
        md_valid = 1; md_addr = 5'd10; md_data = 32'h1010; md_pc = 32'h300;
        wb_we = 1; wb_addr = 5'd11; wb_data = 32'h1111;
        tick();
        md_valid = 0;
        for (int i = 1; i <= MAXW; i++) begin
            @(negedge clk);
            checks++;
            if (stall_req !== 1'b0 || grf_a3 !== 5'd11) begin
                errors++;
                $display("FAIL starve_wait_%0d: stall=%b a3=%0d want 0 11", i, stall_req, grf_a3);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (stall_req !== 1'b1 || grf_a3 !== 5'd11) begin
            errors++;
            $display("FAIL starve_force: stall=%b a3=%0d want 1 11", stall_req, grf_a3);
        end
        tick();
        wb_we = 0;
        @(negedge clk);
        checks++;
        if ({grf_we, grf_a3, grf_wd} !== {1'b1, 5'd10, 32'h1010}) begin
            errors++;
            $display("FAIL starve_drain: we=%b a3=%0d wd=%h want 1 10 1010", grf_we, grf_a3, grf_wd);
        end
        tick();
        @(negedge clk);
        checks++;
        if (stall_req !== 1'b0 || md_ready !== 1'b1) begin
            errors++;
            $display("FAIL starve_release: stall=%b ready=%b want 0 1", stall_req, md_ready);
        end
        tick();
    endtask

    task automatic test_raw_waw();
        do_reset();
        md_valid = 1; md_addr = 5'd12; md_data = 32'hC0C0; md_pc = 32'h400;
        wb_we = 1; wb_addr = 5'd3; wb_data = 32'h3333;
        tick();
        md_valid = 0; rs_addr = 5'd12;
        @(negedge clk);
        checks++;
        if (stall_req !== 1'b1) begin
            errors++;
            $display("FAIL raw_rs: stall=%b want 1", stall_req);
        end
        tick();
        rs_addr = 5'd0; rt_addr = 5'd12;
        wb_addr = 5'd12; wb_data = 32'h7777; wb_pc = 32'h500;
        @(negedge clk);
        checks++;
        if ({grf_we, grf_a3, grf_wd, grf_pc, stall_req} !== {1'b1, 5'd12, 32'h7777, 32'h500, 1'b1}) begin
            errors++;
            $display("FAIL waw_pipe: we=%b a3=%0d wd=%h pc=%h stall=%b", grf_we, grf_a3, grf_wd, grf_pc, stall_req);
        end
        tick();
        wb_we = 0;
        @(negedge clk);
        checks++;
        if ({md_ready, grf_we, stall_req} !== 3'b100) begin
            errors++;
            $display("FAIL waw_cleared: ready/we/stall=%b want 100", {md_ready, grf_we, stall_req});
        end
        tick();
        rt_addr = 5'd0;
    endtask

    task automatic test_perf();
        logic [15:0] exp;
        do_reset();
        md_valid = 1; md_addr = 5'd6; md_data = 32'h66; md_pc = 32'h600;
        wb_we = 1; wb_addr = 5'd11;
        tick();
        md_valid = 0;
        tick(); tick(); tick();
        wb_we = 0;
        tick();
`ifdef GRF_ARB_PERF_EN
        exp = 16'd3;
`else
        exp = 16'd0;
`endif
        @(negedge clk);
        checks++;
        if (perf_wait_cnt !== exp) begin
            errors++;
            $display("FAIL perf_cnt: got %0d want %0d", perf_wait_cnt, exp);
        end
        tick();
    endtask

    task automatic test_reset_midpend();
        do_reset();
        md_valid = 1; md_addr = 5'd7; md_data = 32'h77; md_pc = 32'h700;
        wb_we = 1; wb_addr = 5'd9;
        tick();
        md_valid = 0;
        tick();
        #1 reset = 0;
        #1;
        checks++;
        if ({md_ready, grf_we, stall_req} !== 3'b100) begin
            errors++;
            $display("FAIL midpend_reset: ready/we/stall=%b want 100", {md_ready, grf_we, stall_req});
        end
        tick();
        reset = 1; wb_we = 0;
        @(negedge clk);
        checks++;
        if (grf_we !== 1'b0 || md_ready !== 1'b1) begin
            errors++;
            $display("FAIL midpend_lost: we=%b ready=%b want 0 1", grf_we, md_ready);
        end
        tick();
    endtask

    // Model: one pending result, counts of blocked cycles, sticky starvation flag.
    task automatic test_random();
        bit          m_pend, m_forced, act, drained;
        logic [4:0]  m_addr;
        logic [31:0] m_data, m_pc;
        int          m_blocked, m_perf;
        logic        e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd, e_pc;
        logic        e_stall;
        logic [15:0] e_perf;
        do_reset();
        m_pend = 0; m_forced = 0; m_blocked = 0; m_perf = 0;
        m_addr = 0; m_data = 0; m_pc = 0;
        for (int n = 0; n < 400; n++) begin
            wb_we    = ($urandom_range(0, 9) < 7);
            wb_addr  = 5'($urandom_range(0, 3));
            wb_data  = $urandom; wb_pc = $urandom;
            md_valid = 1'($urandom_range(0, 1));
            md_addr  = 5'($urandom_range(0, 3));
            md_data  = $urandom; md_pc = $urandom;
            rs_addr  = 5'($urandom_range(0, 7));
            rt_addr  = 5'($urandom_range(0, 7));
            act = wb_we && (wb_addr != 0);
            drained = !act && m_pend && (m_addr != 0);
            e_we = 0; e_a3 = 0; e_wd = 0; e_pc = 0;
            if (act) begin
                e_we = 1; e_a3 = wb_addr; e_wd = wb_data; e_pc = wb_pc;
            end else if (drained) begin
                e_we = 1; e_a3 = m_addr; e_wd = m_data; e_pc = m_pc;
            end
            e_stall = m_forced || (m_pend && m_addr != 0 && (rs_addr == m_addr || rt_addr == m_addr));
`ifdef GRF_ARB_PERF_EN
            e_perf = 16'(m_perf);
`else
            e_perf = 16'd0;
`endif
            @(negedge clk);
            checks++;
            if ({md_ready, grf_we, grf_a3, grf_wd, grf_pc, stall_req, perf_wait_cnt} !==
                {!m_pend, e_we, e_a3, e_wd, e_pc, e_stall, e_perf}) begin
                errors++;
                $display("FAIL rand_%0d: ready=%b we=%b a3=%0d wd=%h pc=%h stall=%b perf=%0d want %b %b %0d %h %h %b %0d",
                         n, md_ready, grf_we, grf_a3, grf_wd, grf_pc, stall_req, perf_wait_cnt,
                         !m_pend, e_we, e_a3, e_wd, e_pc, e_stall, e_perf);
            end
            if (m_pend) begin
                if (!drained && m_perf < 65535) m_perf++;
                if (m_addr == 0 || drained || (act && wb_addr == m_addr)) begin
                    m_pend = 0; m_forced = 0; m_blocked = 0;
                end else begin
                    m_blocked++;
                    if (m_blocked >= MAXW) m_forced = 1;
                end
            end else if (md_valid) begin
                m_pend = 1; m_addr = md_addr; m_data = md_data; m_pc = md_pc;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        #2;
        test_reset();
        test_idle_mdu();
        test_drop_zero();
        test_conflict();
        test_starvation();
        test_raw_waw();
        test_perf();
        test_reset_midpend();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
- Shares the single GRF write port between the pipeline W-stage writeback and the multi-cycle mult/div unit (MDU) GPR writeback.
- The pipeline always has priority and is never stalled by the port.
- MDU results wait in a 1-entry holding buffer until the port is free.
- The block raises stall_req for RAW hazards against the pending entry and for starvation.

Parameters:
- MAX_WAIT, 4: cycles a buffered MDU result may wait before starvation stall is forced (1..15).
- CNT_W, 4: width of the internal wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- wb_we  in  1  pipeline W-stage write enable
- wb_addr  in  5  pipeline destination register
- wb_data  in  32  pipeline write data
- wb_pc  in  32  PC of the W-stage instruction
- md_valid  in  1  MDU result valid
- md_addr  in  5  MDU destination register
- md_data  in  32  MDU result
- md_pc  in  32  PC of the issuing MDU instruction
- md_ready  out  1  buffer can accept an MDU result
- rs_addr  in  5  D-stage rs read address
- rt_addr  in  5  D-stage rt read address
- grf_we  out  1  GRF write enable
- grf_a3  out  5  GRF write address
- grf_wd  out  32  GRF write data
- grf_pc  out  32  PC passed to GRF for trace
- stall_req  out  1  freeze F/D, bubble into E
- perf_wait_cnt  out  16  buffered-wait cycle counter (see Optional Feature)

Behaviour:
- State: buf_valid, buf_addr, buf_data, buf_pc, wait_cnt; FSM IDLE / PEND / FORCE.
- Reset (reset=0, async): buf_valid=0, buf fields=0, wait_cnt=0, state=IDLE, perf_wait_cnt=0.
  - All outputs 0 during reset except md_ready, which is 1.
- wb_active = wb_we and wb_addr!=0. Writes to $0 are treated as no write, so the port is free.
- md_ready = !buf_valid (combinational). Accept = md_valid & md_ready; the entry is captured at the edge.
- Grant (combinational):
  - If wb_active: grf_* = wb_*.
  - Else if buf_valid and buf_addr!=0: grf_* = buf_*, and the entry is drained at the edge.
  - Else grf_we=0; grf_a3, grf_wd and grf_pc are 0.
- Latency: pipeline write appears on grf_* in the same cycle. An MDU result reaches the GRF at the earliest one cycle after accept.
- Entry with md_addr=0 is accepted and dropped at the next edge with no GRF write.
- WAW: if wb_active and buf_valid and wb_addr==buf_addr, the buffered entry is discarded at that edge, because the pipeline write is younger. No MDU write occurs and wait_cnt clears.
- Drain and accept in the same cycle cannot happen, since md_ready=0 while buf_valid.
- FSM transitions:
  - IDLE: buf_valid=0, wait_cnt=0. Goes to PEND on accept.
  - PEND: wait_cnt increments each cycle the entry is blocked by wb_active.
    - Goes to IDLE on drain or discard.
    - Goes to FORCE when wait_cnt reaches MAX_WAIT-1 while still blocked.
  - FORCE: stall_req=1. The pipeline is contractually expected to present wb_we=0 within 2 cycles.
    - The block never overrides a wb_active write. It stays in FORCE until drain or discard, then goes to IDLE.
- stall_req (combinational) = (state==FORCE) OR (buf_valid and buf_addr!=0 and (rs_addr==buf_addr or rt_addr==buf_addr)).
- wait_cnt saturates at MAX_WAIT and clears on leaving PEND/FORCE.
- Reset asserted mid-PEND/FORCE: the entry is lost, outputs clear immediately (async), and no GRF write is issued.

Optional Feature:
- Macro GRF_ARB_PERF_EN.
- Defined: perf_wait_cnt is a 16-bit saturating counter, +1 every cycle buf_valid=1 and the entry is not drained. It clears only on reset and holds at 16'hFFFF.
- Undefined: perf_wait_cnt tied to 16'h0000 and no counter flops are synthesized.

Test Plan:
- Reset: hold reset=0 with md_valid=1 and wb_we=1 → grf_we=0, stall_req=0, md_ready=1. Release → no write until the next stimulus.
- Idle MDU path: wb_we=0; md_valid=1, md_addr=5, md_data=32'h0000_1234, md_pc=32'h3008 for 1 cycle.
  - Next cycle: grf_we=1, grf_a3=5, grf_wd=32'h1234, grf_pc=32'h3008.
  - Following cycle: md_ready=1.
- Conflict: accept an MDU entry for $8 while wb_we=1 to $9 for 3 cycles → pipeline writes appear each cycle, md_ready=0. On the 4th cycle, with wb_we=0, the $8 write issues.
- Starvation: MAX_WAIT=4, MDU entry for $10, wb_we=1 to $11 continuously → stall_req rises after 4 blocked cycles. Drop wb_we → $10 written, stall_req falls next cycle.
- RAW and WAW:
  - Buffered $12 with rs_addr=12 → stall_req=1 immediately.
  - wb_we=1, wb_addr=12 → only the pipeline write happens, the buffer clears, md_ready=1 next cycle.
- Perf counter with GRF_ARB_PERF_EN defined: 3 blocked cycles → perf_wait_cnt=3. Undefined → stays 0.
